capture_ctrl: RTL and testbench

//   Sample-capture and readback controller that directly feeds the 8Kx8 sample RAM.

---
 rtl/capture_ctrl.sv | 158 +++++++++++++++
 tb/tb_capture_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: circular-buffer sample capture with a masked pattern trigger and
// oldest-first valid/ready readback from an external synchronous sample RAM.
module capture_ctrl #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SAMPLE_EN,
   input  logic [DATA_W-1:0] PROBE,
   input  logic              ARM,
   input  logic              ABORT,
   input  logic [DATA_W-1:0] TRIG_MASK,
   input  logic [DATA_W-1:0] TRIG_VALUE,
   input  logic [ADDR_W-1:0] POST_COUNT,
   input  logic              RD_START,
   input  logic              RD_READY,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              RD_LAST,
   output logic              BUSY,
   output logic              TRIGGERED,
   output logic              DONE,
   output logic [ADDR_W-1:0] TRIG_ADDR,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_DIN,
   input  logic [DATA_W-1:0] RAM_DOUT,
   output logic [2:0]        dbg_state
);

   // Readback handshake: RD_DATA/RD_VALID/RD_LAST are held until RD_READY is
   // seen with RD_VALID high; the sample transfers on that rising edge.

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_DONE, S_READ} state_t;
   state_t state, state_nx;

   logic [ADDR_W-1:0] wr_ptr, post_left, post_cnt_q, wr_addr_q, rd_addr;
   logic [DATA_W-1:0] trig_mask_q, trig_value_q, wr_din_q;
   logic [ADDR_W:0]   rd_remaining, rd_len;
   logic              wrapped, wr_en_q, rd_inflight;
   logic              arm_go, match, wr_go, trig_go, rd_go, rd_issue, rd_xfer;

   always_comb begin
      arm_go   = ARM && !ABORT && (state == S_IDLE || state == S_DONE);
      match    = ((PROBE ^ trig_value_q) & trig_mask_q) == '0;
      wr_go    = SAMPLE_EN && !ABORT &&
                 (state == S_ARMED || (state == S_POST && post_left != '0));
      trig_go  = wr_go && state == S_ARMED && match;
      rd_len   = wrapped ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, wr_ptr};
      rd_go    = RD_START && !ABORT && !ARM && state == S_DONE && rd_len != '0;
      // one read outstanding at a time, and only when the output slot frees up
      rd_issue = state == S_READ && !ABORT && rd_remaining != '0 && !rd_inflight &&
                 (!RD_VALID || RD_READY);
      rd_xfer  = RD_VALID && RD_READY;
   end

   always_comb begin
      state_nx  = state;
      BUSY      = state == S_ARMED || state == S_POST || state == S_READ;
      DONE      = state == S_DONE;
      RAM_EN    = wr_en_q || rd_issue;
      RAM_WE    = wr_en_q;
      RAM_ADDR  = (state == S_READ) ? rd_addr : wr_addr_q;
      RAM_DIN   = wr_din_q;
      dbg_state = state;
      if (ABORT) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (ARM) state_nx = S_ARMED;
            S_ARMED: if (trig_go) state_nx = S_POST;
            S_POST:  if (post_left == '0) state_nx = S_DONE;
            S_DONE:  if (ARM) state_nx = S_ARMED;
                     else if (rd_go) state_nx = S_READ;
            S_READ:  if (rd_xfer && RD_LAST) state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr       <= '0;
         wrapped      <= 1'b0;
         post_left    <= '0;
         post_cnt_q   <= '0;
         trig_mask_q  <= '0;
         trig_value_q <= '0;
         TRIGGERED    <= 1'b0;
         TRIG_ADDR    <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_din_q     <= '0;
         rd_addr      <= '0;
         rd_remaining <= '0;
         rd_inflight  <= 1'b0;
         RD_DATA      <= '0;
         RD_VALID     <= 1'b0;
         RD_LAST      <= 1'b0;
      end else begin
         wr_en_q <= wr_go;
         if (wr_go) begin
            wr_addr_q <= wr_ptr;
            wr_din_q  <= PROBE;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            if (&wr_ptr) wrapped <= 1'b1;
         end
         if (wr_go && state == S_POST) post_left <= post_left - ADDR_W'(1);
         if (trig_go) begin
            TRIG_ADDR <= wr_ptr;
            TRIGGERED <= 1'b1;
            post_left <= post_cnt_q;
         end
         if (arm_go) begin
            wr_ptr       <= '0;
            wrapped      <= 1'b0;
            TRIGGERED    <= 1'b0;
            post_cnt_q   <= POST_COUNT;
            trig_mask_q  <= TRIG_MASK;
            trig_value_q <= TRIG_VALUE;
         end

         // oldest sample sits at wr_ptr once the ring has wrapped
         rd_inflight <= rd_issue;
         if (rd_go) begin
            rd_addr      <= wrapped ? wr_ptr : '0;
            rd_remaining <= rd_len;
         end
         if (rd_issue) begin
            rd_addr      <= rd_addr + ADDR_W'(1);
            rd_remaining <= rd_remaining - (ADDR_W+1)'(1);
         end
         if (rd_xfer) begin
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
         end
         if (rd_inflight) begin
            RD_DATA  <= RAM_DOUT;
            RD_VALID <= 1'b1;
            RD_LAST  <= rd_remaining == '0;
         end
         if (ABORT) begin
            TRIGGERED   <= 1'b0;
            RD_VALID    <= 1'b0;
            RD_LAST     <= 1'b0;
            rd_inflight <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed capture/readback scenarios checked against a
// ring-buffer model of the written sample stream and a behavioural sample RAM.
module tb_capture_ctrl;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8192;

   logic              CLK, RST_N, SAMPLE_EN, ARM, ABORT, RD_START, RD_READY;
   logic [DATA_W-1:0] PROBE, TRIG_MASK, TRIG_VALUE, RD_DATA, RAM_DIN, RAM_DOUT;
   logic [ADDR_W-1:0] POST_COUNT, TRIG_ADDR, RAM_ADDR;
   logic              RD_VALID, RD_LAST, BUSY, TRIGGERED, DONE, RAM_EN, RAM_WE;
   logic [2:0]        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0]        seq[$];     // probe stream applied after ARM
   logic [ADDR_W+DATA_W-1:0] wq[$];      // expected {addr, data} writes
   logic [DATA_W-1:0]        exp_q[$];   // expected readback stream
   logic [DATA_W-1:0]        rb[$];      // observed readback stream
   logic [DATA_W-1:0]        mem [0:DEPTH-1];
   int                       cap_n;
   int                       wr_mode;    // 0 ignore, 1 expect wq, 2 no write allowed
   logic [ADDR_W-1:0]        first_rd_addr;
   logic                     got_first_rd;
   logic                     prev_stall, prev_abort;
   logic [DATA_W-1:0]        prev_data;

   capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .SAMPLE_EN(SAMPLE_EN), .PROBE(PROBE),
      .ARM(ARM), .ABORT(ABORT), .TRIG_MASK(TRIG_MASK), .TRIG_VALUE(TRIG_VALUE),
      .POST_COUNT(POST_COUNT), .RD_START(RD_START), .RD_READY(RD_READY),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST), .BUSY(BUSY),
      .TRIGGERED(TRIGGERED), .DONE(DONE), .TRIG_ADDR(TRIG_ADDR),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
      .RAM_DOUT(RAM_DOUT), .dbg_state(dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      repeat (200000) @(posedge CLK);
      $display("FAIL watchdog: cycle budget exhausted, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   // synchronous sample RAM, one-cycle read latency
   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
         else        RAM_DOUT <= mem[RAM_ADDR];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({RD_DATA, RD_VALID, RD_LAST, BUSY, TRIGGERED, DONE, TRIG_ADDR,
                  RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN});
   endfunction

   // scoreboard / compare process
   always @(negedge CLK) begin
      if (!RST_N) begin
         prev_stall = 1'b0;
         prev_abort = 1'b0;
      end else begin
         if (wr_mode == 1 && RAM_EN && RAM_WE) begin
            if (wq.size() == 0) check("wr_extra", 64'(RAM_WE), 64'd0);
            else check("wr_addr_data", 64'({RAM_ADDR, RAM_DIN}), 64'(wq.pop_front()));
         end
         if (wr_mode == 2) check("no_write", 64'(RAM_WE), 64'd0);
         if (RAM_EN && !RAM_WE && !got_first_rd) begin
            first_rd_addr = RAM_ADDR;
            got_first_rd  = 1'b1;
         end
         if (prev_stall && !prev_abort) begin
            check("stall_valid", 64'(RD_VALID), 64'd1);
            check("stall_data", 64'(RD_DATA), 64'(prev_data));
         end
         if (RD_VALID && RD_READY) begin
            if (exp_q.size() == 0) begin
               check("rd_extra", 64'(RD_VALID), 64'd0);
            end else begin
               check("rd_data", 64'(RD_DATA), 64'(exp_q[0]));
               check("rd_last", 64'(RD_LAST), 64'(exp_q.size() == 1));
               void'(exp_q.pop_front());
            end
            rb.push_back(RD_DATA);
         end
         prev_stall = RD_VALID && !RD_READY;
         prev_data  = RD_DATA;
         prev_abort = ABORT;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_capture(input logic [7:0] mask, input logic [7:0] value,
                              input logic [12:0] post);
      int t, k;
      t = -1;
      for (int i = 0; i < seq.size(); i++)
         if (t < 0 && ((seq[i] ^ value) & mask) == 8'h00) t = i;
      cap_n = t + 1 + int'(post);
      wq.delete();
      for (int i = 0; i < cap_n; i++) wq.push_back({ADDR_W'(i), seq[i]});
      wr_mode = 1;
      TRIG_MASK = mask; TRIG_VALUE = value; POST_COUNT = post;
      ARM = 1'b1;
      tick();
      ARM = 1'b0;
      check("arm_busy", 64'(BUSY), 64'd1);
      check("arm_trig_clear", 64'(TRIGGERED), 64'd0);
      for (int i = 0; i < seq.size(); i++) begin
         SAMPLE_EN = 1'b1;
         PROBE = seq[i];
         tick();
      end
      SAMPLE_EN = 1'b0;
      k = 0;
      while (!DONE && k < 50) begin
         tick();
         k++;
      end
      check("cap_done", 64'(DONE), 64'd1);
      check("cap_triggered", 64'(TRIGGERED), 64'd1);
      check("cap_trig_addr", 64'(TRIG_ADDR), 64'(t % DEPTH));
      check("cap_writes_left", 64'(wq.size()), 64'd0);
      wr_mode = 2;
   endtask

   task automatic readback(input int rmode);
      int m, k;
      m = (cap_n < DEPTH) ? cap_n : DEPTH;
      exp_q.delete();
      rb.delete();
      got_first_rd = 1'b0;
      for (int i = cap_n - m; i < cap_n; i++) exp_q.push_back(seq[i]);
      RD_START = 1'b1;
      tick();
      RD_START = 1'b0;
      k = 0;
      while ((exp_q.size() != 0 || !DONE) && k < 40000) begin
         RD_READY = rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         k++;
      end
      RD_READY = 1'b0;
      check("rd_done", 64'(DONE), 64'd1);
      check("rd_exp_left", 64'(exp_q.size()), 64'd0);
      check("rd_count", 64'(rb.size()), 64'(m));
      check("rd_valid_idle", 64'(RD_VALID), 64'd0);
   endtask

   initial begin
      RST_N = 1'b0; SAMPLE_EN = 1'b0; PROBE = '0; ARM = 1'b0; ABORT = 1'b0;
      TRIG_MASK = '0; TRIG_VALUE = '0; POST_COUNT = '0; RD_START = 1'b0;
      RD_READY = 1'b0; wr_mode = 0; got_first_rd = 1'b0; cap_n = 0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_outputs", outs(), 64'd0);
      check("reset_state", 64'(dbg_state), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();

      // ramp, exact trigger on A5, three post samples
      seq.delete();
      for (int i = 0; i < 200; i++) seq.push_back(8'(i));
      run_capture(8'hFF, 8'hA5, 13'd3);
      check("t1_trig_addr", 64'(TRIG_ADDR), 64'h0A5);
      readback(0);
      check("t1_first_rd_addr", 64'(first_rd_addr), 64'd0);
      check("t1_count", 64'(rb.size()), 64'd169);
      check("t1_first_byte", 64'(rb[0]), 64'h00);
      check("t1_last_byte", 64'(rb[168]), 64'hA8);
      readback(1);
      check("t1_reread_count", 64'(rb.size()), 64'd169);

      // ARM and ABORT together while DONE
      ARM = 1'b1; ABORT = 1'b1;
      tick();
      ARM = 1'b0; ABORT = 1'b0;
      check("armabort_state", 64'(dbg_state), 64'd0);
      check("armabort_busy", 64'(BUSY), 64'd0);
      check("armabort_done", 64'(DONE), 64'd0);
      check("armabort_trig", 64'(TRIGGERED), 64'd0);

      // mask 0 triggers on first sample, full ring of post samples
      seq.delete();
      for (int i = 0; i < DEPTH; i++) seq.push_back(8'((i * 37) + (i >> 8)));
      run_capture(8'h00, 8'h3C, 13'd8191);
      check("t2_trig_addr", 64'(TRIG_ADDR), 64'd0);
      readback(0);
      check("t2_first_rd_addr", 64'(first_rd_addr), 64'd0);
      check("t2_count", 64'(rb.size()), 64'd8192);

      // abort in the middle of a stalled readback
      exp_q.delete();
      RD_START = 1'b1;
      tick();
      RD_START = 1'b0;
      repeat (4) tick();
      check("abort_pre_valid", 64'(RD_VALID), 64'd1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      check("abort_rd_valid", 64'(RD_VALID), 64'd0);
      check("abort_state", 64'(dbg_state), 64'd0);
      check("abort_trig", 64'(TRIGGERED), 64'd0);
      check("abort_busy", 64'(BUSY), 64'd0);
      repeat (3) tick();
      check("abort_rd_valid_later", 64'(RD_VALID), 64'd0);

      // pre-trigger wrap: 10000 non-matching samples, then match, 10 post
      seq.delete();
      for (int i = 0; i < 10000; i++) seq.push_back((8'(i) == 8'hA5) ? 8'h5A : 8'(i));
      seq.push_back(8'hA5);
      for (int i = 0; i < 12; i++) seq.push_back(8'(i * 3));
      run_capture(8'hFF, 8'hA5, 13'd10);
      check("t3_trig_addr", 64'(TRIG_ADDR), 64'd1808);
      readback(1);
      check("t3_first_rd_addr", 64'(first_rd_addr), 64'd1819);
      check("t3_count", 64'(rb.size()), 64'd8192);
      check("t3_trig_byte", 64'(rb[8181]), 64'hA5);

      // asynchronous reset in the middle of POST
      seq.delete();
      for (int i = 0; i < 20; i++) seq.push_back(8'(i));
      wr_mode = 0;
      TRIG_MASK = 8'hFF; TRIG_VALUE = 8'h00; POST_COUNT = 13'd100;
      ARM = 1'b1;
      tick();
      ARM = 1'b0;
      for (int i = 0; i < 10; i++) begin
         SAMPLE_EN = 1'b1;
         PROBE = seq[i];
         tick();
      end
      check("post_busy", 64'(BUSY), 64'd1);
      check("post_triggered", 64'(TRIGGERED), 64'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("rst_async_outputs", outs(), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      wr_mode = 2;
      for (int i = 0; i < 6; i++) begin
         SAMPLE_EN = 1'b1;
         PROBE = 8'($urandom_range(0, 255));
         tick();
      end
      SAMPLE_EN = 1'b0;
      check("rst_idle_state", 64'(dbg_state), 64'd0);
      check("rst_idle_busy", 64'(BUSY), 64'd0);
      check("rst_idle_trig", 64'(TRIGGERED), 64'd0);
      wr_mode = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
